// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Fetch FSM states, the canonical NOP and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register between fetch and decode.
// Priority: flush, then stall, then load, otherwise bubble.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  // Stage register update with flush > stall > load > bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_d    <= instr;
        pc_d       <= pc;
        pc_plus4_d <= pc + XLEN'(4);
        valid_d    <= 1'b1;
      end else begin
        instr_d    <= NOP_INSTR;
        pc_d       <= '0;
        pc_plus4_d <= '0;
        valid_d    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake and IF/ID.
// DROP keeps a stale request stable until its response returns.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] drop_q, drop_d;
  logic [31:0]     hold_q, hold_d;
  logic            deliver;
  logic [31:0]     deliver_instr;

  // FSM state, PC and buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pcf_q   <= RESET_PC;
      drop_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, PC update and memory request generation.
  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    drop_d        = drop_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;
    imem_req      = 1'b1;
    imem_addr     = pcf_q;
    unique case (state_q)
      FETCH: begin
        if (PCSrcE) begin
          pcf_d = PCTargetE;
          if (!imem_ready) begin
            drop_d  = pcf_q;
            state_d = DROP;
          end
        end else if (imem_ready) begin
          if (!StallD && !FlushD) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pcf_d         = pcf_q + XLEN'(4);
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        imem_req = 1'b0;
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = FETCH;
        end else if (!StallD && !FlushD) begin
          deliver = 1'b1;
          pcf_d   = pcf_q + XLEN'(4);
          state_d = FETCH;
        end
      end
      DROP: begin
        imem_addr = drop_q;
        if (PCSrcE) pcf_d = PCTargetE;
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  if_id_register #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (FlushD),
    .stall      (StallD),
    .load       (deliver),
    .instr      (deliver_instr),
    .pc         (pcf_q),
    .instr_d    (InstrD),
    .pc_d       (PCD),
    .pc_plus4_d (PCPlus4D),
    .valid_d    (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit.
// Expected deliveries are queued and popped as decode consumes them.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  assign imem_rdata = word(imem_addr);

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  // One clock; decode consumes ID at mid-cycle when not stalled/flushed.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!reset && ValidD === 1'b1 && !StallD && !FlushD) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h want none",
                 PCD, InstrD);
      end else begin
        e = sb.pop_front();
        if (PCD !== e.pc || InstrD !== e.instr ||
            PCPlus4D !== e.pc + 32'd4) begin
          miscompares++;
          $display("FAIL sb_deliver: got pc=%h p4=%h instr=%h want pc=%h instr=%h",
                   PCD, PCPlus4D, InstrD, e.pc, e.instr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = word(pc);
    sb.push_back(e);
  endtask

  task automatic check_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    imem_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++;
    if (ValidD !== 1'b0 || InstrD !== 32'h13 || PCD !== 0 || PCPlus4D !== 0) begin
      miscompares++;
      $display("FAIL reset_ifid: got v=%b i=%h pc=%h p4=%h want 0 00000013 0 0",
               ValidD, InstrD, PCD, PCPlus4D);
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_req: got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    reset_dut();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL zw_addr: got %h want %h", imem_addr, 32'(4 * i));
      end
      push(32'(4 * i));
      cycle();
      if (i == 0) begin
        vectors++;
        if (ValidD !== 1'b1) begin
          miscompares++;
          $display("FAIL zw_first_valid: got %b want 1", ValidD);
        end
      end
    end
    imem_ready = 1'b0;
    cycle();
    check_empty("zw");
  endtask

  task automatic test_latency2();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      vectors++;
      if (imem_addr !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL lat_addr0: got %h want %h", imem_addr, 32'(4 * i));
      end
      cycle();
      vectors++;
      if (ValidD !== 1'b0 || imem_addr !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL lat_hold: got v=%b addr=%h want 0 %h",
                 ValidD, imem_addr, 32'(4 * i));
      end
      imem_ready = 1'b1;
      push(32'(4 * i));
      cycle();
    end
    imem_ready = 1'b0;
    cycle();
    check_empty("lat");
  endtask

  task automatic test_stall_hold();
    reset_dut();
    imem_ready = 1'b1;
    push(32'h0);
    cycle();
    push(32'h4);
    cycle();
    StallD = 1'b1;
    cycle();
    vectors++;
    if (imem_req !== 1'b0 || PCD !== 32'h4 || ValidD !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold: got req=%b pc=%h v=%b want 0 4 1",
               imem_req, PCD, ValidD);
    end
    imem_ready = 1'b0;
    cycle();
    cycle();
    StallD = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || PCD !== 32'h4) begin
      miscompares++;
      $display("FAIL stall_frozen: got req=%b pc=%h want 0 4", imem_req, PCD);
    end
    push(32'h8);
    cycle();
    vectors++;
    if (PCD !== 32'h8 || ValidD !== 1'b1 || imem_req !== 1'b1 ||
        imem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h v=%b req=%b addr=%h want 8 1 1 c",
               PCD, ValidD, imem_req, imem_addr);
    end
    cycle();
    check_empty("stall");
  endtask

  task automatic test_drop();
    reset_dut();
    imem_ready = 1'b1;
    push(32'h0);
    cycle();
    push(32'h4);
    cycle();
    push(32'h8);
    cycle();
    imem_ready = 1'b0;
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    cycle();
    PCSrcE = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || ValidD !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_enter: got req=%b addr=%h v=%b want 1 c 0",
               imem_req, imem_addr, ValidD);
    end
    cycle();
    vectors++;
    if (imem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL drop_stable: got %h want c", imem_addr);
    end
    imem_ready = 1'b1;
    cycle();
    vectors++;
    if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL drop_exit: got v=%b req=%b addr=%h want 0 1 100",
               ValidD, imem_req, imem_addr);
    end
    push(32'h100);
    cycle();
    imem_ready = 1'b0;
    cycle();
    check_empty("drop");
  endtask

  task automatic test_redirect_flush();
    reset_dut();
    imem_ready = 1'b1;
    cycle();
    vectors++;
    if (PCD !== 32'h0 || ValidD !== 1'b1) begin
      miscompares++;
      $display("FAIL rf_pre: got pc=%h v=%b want 0 1", PCD, ValidD);
    end
    PCSrcE = 1'b1;
    FlushD = 1'b1;
    PCTargetE = 32'h200;
    cycle();
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    vectors++;
    if (InstrD !== 32'h13 || ValidD !== 1'b0 || imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL rf_flush: got i=%h v=%b addr=%h want 13 0 200",
               InstrD, ValidD, imem_addr);
    end
    push(32'h200);
    cycle();
    imem_ready = 1'b0;
    cycle();
    check_empty("rf");
  endtask

  task automatic test_reset_hold_wrap();
    reset_dut();
    imem_ready = 1'b1;
    cycle();
    StallD = 1'b1;
    cycle();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rh_inhold: got req=%b want 0", imem_req);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    StallD = 1'b0;
    imem_ready = 1'b0;
    vectors++;
    if (ValidD !== 1'b0 || InstrD !== 32'h13 || imem_req !== 1'b1 ||
        imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rh_reset: got v=%b i=%h req=%b addr=%h want 0 13 1 0",
               ValidD, InstrD, imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    cycle();
    PCSrcE = 1'b0;
    vectors++;
    if (ValidD !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_target: got v=%b addr=%h want 0 fffffffc",
               ValidD, imem_addr);
    end
    push(32'hFFFF_FFFC);
    cycle();
    vectors++;
    if (imem_addr !== 32'h0 || PCPlus4D !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: got addr=%h p4=%h want 0 0",
               imem_addr, PCPlus4D);
    end
    imem_ready = 1'b0;
    cycle();
    check_empty("wrap");
  endtask

  initial begin
    reset = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    imem_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency2();
    test_stall_hold();
    test_drop();
    test_redirect_flush();
    test_reset_hold_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of decode/control.
- Owns PCF, the instruction-memory request handshake (variable latency) and the IF/ID pipeline register.
- Delivers InstrD/PCD/PCPlus4D, from which decode extracts opcode/f3/f7.
- Honours StallD and FlushD from the hazard unit, and PCSrcE/PCTargetE redirects from execute.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- StallD  in  1  hazard unit: hold IF/ID contents.
- FlushD  in  1  hazard unit: clear IF/ID to bubble.
- PCSrcE  in  1  execute: taken branch/jump/jalr redirect.
- PCTargetE  in  XLEN  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response valid this cycle; meaningful only when imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ready.
- InstrD  out  32  decode-stage instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).

Behaviour:
- Reset (synchronous): PCF=RESET_PC, state=FETCH, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0, hold buffer cleared. imem_req=1 from the first cycle after reset.
- A response is accepted when imem_req && imem_ready. Addresses wrap modulo 2^XLEN (PCF+4 at 32'hFFFF_FFFC gives 0).
- State FETCH (imem_req=1, imem_addr=PCF):
  - PCSrcE && imem_ready: discard response; PCF<=PCTargetE; stay in FETCH.
  - PCSrcE && !imem_ready: DropAddr<=PCF; PCF<=PCTargetE; go to DROP.
  - imem_ready && !StallD && !FlushD: deliver to IF/ID; PCF<=PCF+4; stay in FETCH.
  - imem_ready && (StallD || FlushD): buffer the word and PCF; go to HOLD.
  - Otherwise: wait.
- State HOLD (imem_req=0):
  - PCSrcE: discard buffer; PCF<=PCTargetE; go to FETCH.
  - !StallD && !FlushD: deliver buffer; PCF<=PCF+4; go to FETCH.
  - Otherwise: stay in HOLD.
- State DROP (imem_req=1, imem_addr=DropAddr, keeping the outstanding request stable):
  - imem_ready: discard response; go to FETCH at PCF.
  - PCSrcE in DROP: PCF<=PCTargetE; stay in DROP.
- IF/ID register, priority order:
  1. FlushD: NOP, ValidD=0.
  2. StallD: hold all outputs.
  3. Delivery this cycle: InstrD/PCD/PCPlus4D loaded, ValidD=1.
  4. Otherwise: NOP bubble, ValidD=0.
- Latency: zero-wait memory (imem_ready same cycle as request) gives one instruction per cycle; InstrD appears the cycle after acceptance.
- A redirect never delivers a wrong-path instruction. The first target instruction is requested the cycle after PCSrcE (FETCH/HOLD) or after the dropped response returns (DROP).
- reset overrides all inputs in any state. A response arriving in the reset cycle is ignored.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t {FETCH, HOLD, DROP}.
  - Default RESET_PC.
- Sub-module if_id_register: holds InstrD/PCD/PCPlus4D/ValidD and applies the flush > stall > load > bubble priority.
- The FSM, PCF, DropAddr and hold buffer stay in fetch_unit.

Test Plan:
1. Reset, then zero-wait memory returning addr-tagged words: PCD sequence 0,4,8,C on consecutive cycles; ValidD=1 from the second cycle after reset; InstrD matches the words.
2. Memory with 2-cycle latency: imem_addr held at 0x4 for 2 cycles; ValidD=0 bubbles between instructions; PCD 0,4,8 in order.
3. StallD=1 for 3 cycles while the response for 0x8 arrives: state goes to HOLD, imem_req=0, IF/ID frozen at 0x4. After release, PCD=0x8 next cycle, then a request for 0xC.
4. PCSrcE=1, PCTargetE=0x100, with imem_ready=0 on 0xC: go to DROP with imem_addr=0xC. Late response discarded; next request is 0x100; PCD=0x100 with no wrong-path ValidD.
5. PCSrcE and FlushD together with imem_ready=1: InstrD=0x13, ValidD=0; next imem_addr=target.
6. reset asserted mid-HOLD: next cycle PCF=RESET_PC, ValidD=0, imem_req=1, imem_addr=RESET_PC; PC wrap check: fetch at 0xFFFF_FFFC, next addr 0x0.
